// File: rtl/multicore_sobel_oci_dct_pkg.sv
// Shared definitions for the cpu_0 OCI direct-control-transfer (DCT) trace
// path. Used by the DCT packer, the OCI trace FIFO and the OCI test bench.
//   CODE_W : width of one DCT code
//   SLOTS  : codes per packed trace word
//   CNT_W  : width of the per-word code count (holds SLOTS)
//   BUF_W  : width of the packed trace word
//   DCT_*  : named code values
package multicore_sobel_oci_dct_pkg;

  localparam int CODE_W = 2;
  localparam int SLOTS  = 15;
  localparam int CNT_W  = 4;
  localparam int BUF_W  = CODE_W * SLOTS;

  localparam logic [CODE_W-1:0] DCT_NONE = 2'b00;
  localparam logic [CODE_W-1:0] DCT_NT   = 2'b01;
  localparam logic [CODE_W-1:0] DCT_TK   = 2'b10;
  localparam logic [CODE_W-1:0] DCT_IND  = 2'b11;

endpackage

// File: rtl/multicore_sobel_cpu_0_oci_dct_outreg.sv
// Valid/ready holding register for packed DCT trace words.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   load         : capture load_buffer/load_count this cycle (only asserted
//                  by the packer when the slot is free)
//   load_buffer  : packed word to capture
//   load_count   : number of codes in load_buffer
//   dct_ready    : sink accepts the held word this cycle
//   dct_valid    : a word is held
//   dct_buffer   : held packed word
//   dct_count    : held code count
// Outputs are straight flop outputs, so dct_ready never reaches them
// combinationally.
module multicore_sobel_cpu_0_oci_dct_outreg
  import multicore_sobel_oci_dct_pkg::*;
#(
  parameter int BW    = multicore_sobel_oci_dct_pkg::BUF_W,
  parameter int CW    = multicore_sobel_oci_dct_pkg::CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [BW-1:0] load_buffer,
  input  logic [CW-1:0] load_count,
  input  logic          dct_ready,
  output logic          dct_valid,
  output logic [BW-1:0] dct_buffer,
  output logic [CW-1:0] dct_count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      dct_valid  <= 1'b0;
      dct_buffer <= '0;
      dct_count  <= '0;
    end else if (load) begin
      dct_valid  <= 1'b1;
      dct_buffer <= load_buffer;
      dct_count  <= load_count;
    end else if (dct_ready) begin
      dct_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/multicore_sobel_cpu_0_oci_dct_packer.sv
// Packs 2-bit DCT codes from the cpu_0 trace logic into 15-code words and
// hands them to the OCI trace FIFO over a valid/ready handshake.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   code_valid   : code presented this cycle
//   code         : DCT code (all values are data)
//   flush        : emit the current partial word
//   dct_ready    : sink accepts the output word
//   dct_valid    : output word present
//   dct_buffer   : packed codes, oldest code in the highest used slot
//   dct_count    : number of codes in dct_buffer (1..15)
//   overflow     : one-cycle pulse after a code was dropped
//   drop_count   : saturating count of dropped codes
module multicore_sobel_cpu_0_oci_dct_packer
  import multicore_sobel_oci_dct_pkg::*;
#(
  parameter int CODE_W = multicore_sobel_oci_dct_pkg::CODE_W,
  parameter int SLOTS  = multicore_sobel_oci_dct_pkg::SLOTS,
  parameter int CNT_W  = multicore_sobel_oci_dct_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    code_valid,
  input  logic [CODE_W-1:0]       code,
  input  logic                    flush,
  input  logic                    dct_ready,
  output logic                    dct_valid,
  output logic [CODE_W*SLOTS-1:0] dct_buffer,
  output logic [CNT_W-1:0]        dct_count,
  output logic                    overflow,
  output logic [7:0]              drop_count
);

  localparam int BW = CODE_W * SLOTS;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

  logic [BW-1:0]    acc;
  logic [CNT_W-1:0] acc_cnt;
  logic             flush_pend;

  logic             full;
  logic             slot_free;
  logic             flush_any;
  logic [BW-1:0]    nxt_acc;
  logic [CNT_W-1:0] nxt_cnt;
  logic             complete;
  logic             load;
  logic             refill;
  logic             drop;
  logic [BW-1:0]    acc_d;
  logic [CNT_W-1:0] cnt_d;
  logic             flush_pend_d;

  always_comb begin
    full      = (acc_cnt == FULL_CNT);
    slot_free = !dct_valid || dct_ready;
    flush_any = flush || flush_pend;

    // A full accumulator takes no code; it is already a complete word.
    nxt_acc = acc;
    nxt_cnt = acc_cnt;
    if (code_valid && !full) begin
      nxt_acc = {acc[BW-CODE_W-1:0], code};
      nxt_cnt = acc_cnt + 1'b1;
    end

    complete = (nxt_cnt == FULL_CNT) || (flush_any && (nxt_cnt != '0));
    load     = complete && slot_free;

    // A code meeting a full accumulator is kept only if the full word leaves
    // this cycle; it then starts the fresh accumulator at count 1.
    refill = code_valid && full && slot_free;
    drop   = code_valid && full && !slot_free;

    if (load) begin
      acc_d        = refill ? BW'(code) : '0;
      cnt_d        = refill ? CNT_W'(1) : '0;
      flush_pend_d = refill && flush;
    end else begin
      acc_d        = nxt_acc;
      cnt_d        = nxt_cnt;
      // Flush on an empty accumulator is a no-op, so it is not remembered.
      flush_pend_d = flush_any && (nxt_cnt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      acc_cnt    <= '0;
      flush_pend <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      acc        <= acc_d;
      acc_cnt    <= cnt_d;
      flush_pend <= flush_pend_d;
      overflow   <= drop;
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  multicore_sobel_cpu_0_oci_dct_outreg #(
    .BW (BW),
    .CW (CNT_W)
  ) u_outreg (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_buffer (nxt_acc),
    .load_count  (nxt_cnt),
    .dct_ready   (dct_ready),
    .dct_valid   (dct_valid),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count)
  );

endmodule

// File: tb/tb_multicore_sobel_cpu_0_oci_dct_packer.sv
module tb_multicore_sobel_cpu_0_oci_dct_packer;

  logic        clk;
  logic        reset;
  logic        code_valid;
  logic [1:0]  code;
  logic        flush;
  logic        dct_ready;
  logic        dct_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic [7:0]  drop_count;

  typedef struct {
    logic [29:0] buffer;
    logic [3:0]  count;
  } word_t;

  word_t sb_q[$];
  int checks;
  int fails;

  multicore_sobel_cpu_0_oci_dct_packer #(
    .CODE_W (2),
    .SLOTS  (15),
    .CNT_W  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .code       (code),
    .flush      (flush),
    .dct_ready  (dct_ready),
    .dct_valid  (dct_valid),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [29:0] b, input logic [3:0] c);
    word_t w;
    w.buffer = b;
    w.count  = c;
    sb_q.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    code_valid = 1'b1;
    code       = c;
    tick();
    code_valid = 1'b0;
  endtask

  // Monitor: every handshake must match the oldest expected word.
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      if (!reset && dct_valid && dct_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_word: actual buffer=%h count=%0d, required no word",
                   dct_buffer, dct_count);
        end else begin
          w = sb_q.pop_front();
          check("word_buffer", 32'(dct_buffer), 32'(w.buffer));
          check("word_count",  32'(dct_count),  32'(w.count));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] pat [4];
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b11; pat[3] = 2'b00;
    checks = 0;
    fails  = 0;
    reset = 1'b1; code_valid = 1'b0; code = 2'b00; flush = 1'b0; dct_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset_valid",  32'(dct_valid),  32'd0);
    check("reset_buffer", 32'(dct_buffer), 32'd0);
    check("reset_count",  32'(dct_count),  32'd0);
    check("reset_ovf",    32'(overflow),   32'd0);
    check("reset_drops",  32'(drop_count), 32'd0);

    // Full word, oldest code highest.
    expect_word(30'h1B1B1B1B, 4'd15);
    for (int i = 0; i < 15; i++) send(pat[i % 4]);
    check("full_latency_valid", 32'(dct_valid), 32'd1);
    check("full_latency_count", 32'(dct_count), 32'd15);
    tick();

    // Partial flush, then an empty flush that must emit nothing.
    expect_word(30'h036, 4'd3);
    send(2'b11); send(2'b01); send(2'b10);
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush_latency_valid", 32'(dct_valid), 32'd1);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    tick(); tick();

    // Backpressure and overflow: codes k[1:0] for k = 0..31.
    dct_ready = 1'b0;
    expect_word(30'h06C6C6C6, 4'd15);
    expect_word(30'h31B1B1B1, 4'd15);
    for (int k = 0; k < 32; k++) begin
      send(2'(k));
      if (k == 19) check("hold_buffer_mid", 32'(dct_buffer), 32'h06C6C6C6);
      if (k == 29) check("ovf_before_full_drop", 32'(overflow), 32'd0);
      if (k == 30) check("ovf_code31", 32'(overflow), 32'd1);
      if (k == 31) check("ovf_code32", 32'(overflow), 32'd1);
    end
    check("hold_valid_end",  32'(dct_valid),  32'd1);
    check("hold_buffer_end", 32'(dct_buffer), 32'h06C6C6C6);
    tick();
    check("ovf_clears",   32'(overflow),   32'd0);
    check("drops_two",    32'(drop_count), 32'd2);
    dct_ready = 1'b1;
    tick();
    check("second_word_count", 32'(dct_count), 32'd15);
    tick(); tick();

    // Code and flush in the same cycle.
    expect_word(30'h156, 4'd5);
    for (int i = 0; i < 4; i++) send(2'b01);
    flush = 1'b1; send(2'b10); flush = 1'b0;
    tick(); tick();

    // Reset mid-word.
    for (int i = 0; i < 7; i++) send(2'b11);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_reset_valid",  32'(dct_valid),  32'd0);
    check("mid_reset_buffer", 32'(dct_buffer), 32'd0);
    check("mid_reset_count",  32'(dct_count),  32'd0);
    check("mid_reset_drops",  32'(drop_count), 32'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    tick(); tick();
    expect_word(30'h2AAAAAAA, 4'd15);
    for (int i = 0; i < 15; i++) send(2'b10);
    tick(); tick();

    // Drop counter saturation.
    dct_ready = 1'b0;
    expect_word(30'h15555555, 4'd15);
    expect_word(30'h15555555, 4'd15);
    for (int i = 0; i < 300; i++) begin
      send(2'b01);
      if (i == 129) check("drops_100", 32'(drop_count), 32'd100);
      if (i == 284) check("drops_255", 32'(drop_count), 32'd255);
    end
    check("drops_saturated", 32'(drop_count), 32'd255);
    dct_ready = 1'b1;
    tick(); tick(); tick(); tick();

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/multicore_sobel_cpu_0_oci_dct_packer.md
# multicore_sobel_cpu_0_oci_dct_packer

Producer side of the OCI direct-control-transfer (DCT) trace path for cpu_0. Accepts one 2-bit DCT code per cycle from the CPU trace logic and packs up to 15 codes into a 30-bit `dct_buffer` word with a 4-bit `dct_count`. The word is emitted on a valid/ready handshake to the trace sink or the OCI test bench. It sits between the CPU retire/branch tracker and the OCI trace FIFO.

## Interface
Parameters:
- `CODE_W`, 2: width of one DCT code.
- `SLOTS`, 15: codes per packed word. Buffer width is `CODE_W*SLOTS` = 30.
- `CNT_W`, 4: width of `dct_count`. Must hold the value `SLOTS`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `code_valid`  in  1  `code` is presented this cycle.
- `code`  in  2  DCT code. All four values are data.
- `flush`  in  1  emit the partial word (end of trace or trigger).
- `dct_ready`  in  1  sink accepts the word this cycle.
- `dct_valid`  out  1  `dct_buffer` and `dct_count` hold a word.
- `dct_buffer`  out  30  packed codes.
- `dct_count`  out  4  number of valid codes in `dct_buffer`, 1..15.
- `overflow`  out  1  one-cycle pulse: a code was dropped.
- `drop_count`  out  8  saturating count of dropped codes.

## Operation
- **Accumulator.** Holds `acc[29:0]` and `acc_cnt` (0..15).
  - An accepted code shifts in at the LSB: `acc <= {acc[27:0], code}`.
  - The oldest code sits highest. Unused upper bits of a partial word are 0.
- **Output register.** Holds `dct_buffer`, `dct_count` and `dct_valid`.
  - The slot is *free* when `!dct_valid || dct_ready`.
  - While `dct_valid && !dct_ready`, all outputs hold stable.
- **Completion.** Let `nxt` be the accumulator after this cycle's accept.
  - If `nxt` has count 15, or `flush` is high and `nxt` has count > 0, the word is complete.
  - If the slot is free, `nxt` loads into the output register and the accumulator clears to count 0 in the same cycle.
  - If the slot is busy, the accumulator holds `nxt` and transfers on the first cycle the slot is free.
  - A pending flush is latched in `flush_pend` until the transfer happens.
- **Full / drop.** When `acc_cnt == 15` and the word has not yet transferred, an incoming code is dropped.
  - `overflow` pulses for one cycle.
  - `drop_count` increments and saturates at 255.
  - If the transfer happens in the same cycle, the slot frees, so the code is accepted into the cleared accumulator at count 1 and no drop occurs.
- **Flush with no data.** Flush while the accumulator is empty and no code arrives is a no-op. No zero-count word is ever emitted.
- **Simultaneous `code_valid` and `flush`.** The code is included in the flushed word.
- **Flush while a word is pending.** Codes arriving after the flush go to a fresh accumulator only after the pending transfer. Until then, the full/drop rule above applies.
- **Reset.** Values after reset:
  - `dct_valid` = 0, `dct_buffer` = 0, `dct_count` = 0.
  - `acc` = 0, `acc_cnt` = 0, `flush_pend` = 0.
  - `overflow` = 0, `drop_count` = 0.
  - Reset mid-word discards the partial word and any held output word.

## Timing
- Code accepted at edge N that completes a word: `dct_valid` = 1 after edge N. Latency is one cycle.
- Flush at edge N with a non-empty accumulator and a free slot: word valid after edge N.
- Sustained throughput: one code per cycle with no drops while `dct_ready` stays high.
  - Back-to-back full words are emitted every 15 cycles.
- `overflow` is registered and is high in the cycle after the dropped code's edge.
- No combinational path from `dct_ready` to any output.

## Structure
- Package `multicore_sobel_oci_dct_pkg` holds `CODE_W`, `SLOTS`, `CNT_W` and the derived `BUF_W`. The OCI test bench and trace FIFO share it.
- Package `multicore_sobel_oci_dct_pkg` also defines named code constants: `DCT_NONE`=00, `DCT_NT`=01, `DCT_TK`=10, `DCT_IND`=11.
- One natural sub-module: `multicore_sobel_cpu_0_oci_dct_outreg`, the valid/ready output holding register.
- Accumulator, completion logic and drop logic stay in the top module.

## Test plan
- **Full word.** Send 15 codes 01,10,11,00,… repeating, with `dct_ready`=1.
  - Required: one cycle after the 15th code, `dct_valid`=1, `dct_count`=15.
  - Required: `dct_buffer` = 30'h1B1B_1B1B masked to 30 bits (oldest code highest).
- **Partial flush.** Send 3 codes 11,01,10, then flush.
  - Required: `dct_count`=3, `dct_buffer`=30'h036.
  - Then flush again with no codes. Required: no word.
- **Backpressure and overflow.** Set `dct_ready`=0 and send 32 codes.
  - Required: the first word is held stable.
  - Required: the accumulator fills to 15; codes 31 and 32 each pulse `overflow`; `drop_count`=2.
  - Release `dct_ready`. Required: the second word is emitted with `dct_count`=15.
- **Simultaneous code and flush.** After 4 codes, drive `code_valid`=1 with `code`=10 and `flush` in the same cycle.
  - Required: `dct_count`=5 and the LSBs are 10.
- **Reset mid-word.** Send 7 codes, then assert `reset` for 1 cycle.
  - Required: all outputs 0.
  - A following flush emits nothing. The next 15 codes produce exactly one word.
- **Saturation.** Hold `dct_ready`=0 and stream 300 codes.
  - Required: `drop_count` stops at 255.
